// File: rtl/board_io_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_frontend
//  Purpose  : Switch synchroniser, button debouncer with press pulses, and a
//             multiplexed common-anode hex display driver with dead time.
//  Revision : 1.0 - initial release
// ============================================================================
module board_io_frontend #(
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 5,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_SW-1:0]       sw_pad,
    input  logic [NUM_BTN-1:0]      btn_pad,
    output logic [NUM_SW-1:0]       sw_sync,
    output logic [NUM_BTN-1:0]      btn_level,
    output logic [NUM_BTN-1:0]      btn_press,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]   digit_dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PRE_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Two-stage synchronisers
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0]  sw_s1_q,  sw_s2_q;
    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            sw_s1_q  <= sw_pad;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn_pad;
            btn_s2_q <= btn_s1_q;
        end
    end

    assign sw_sync = sw_s2_q;

    // ------------------------------------------------------------------
    // Per-button debouncer and rising-edge pulse
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             press_q;

            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                if (btn_s2_q[i] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    level_d = btn_s2_q[i];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    press_q <= level_d & ~level_q;
                end
            end

            assign btn_level[i] = level_q;
            assign btn_press[i] = press_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Refresh prescaler and digit index
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == C_PRE_MAX) begin
            pre_d = '0;
            idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display output registers
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    logic [3:0]            w_cur_val;
    logic                  w_cur_en;
    logic                  w_cur_dp;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q,  dp_d;
    logic [NUM_DIGITS-1:0] an_q,  an_d;

    assign w_cur_val = digit_val[{idx_q, 2'b00} +: 4];
    assign w_cur_en  = digit_en[idx_q];
    assign w_cur_dp  = digit_dp[idx_q];

    // Prescaler value 0 is the blanked dead-time cycle between digits.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (pre_q != '0) begin
            an_d[idx_q] = ~w_cur_en;
            if (w_cur_en) begin
                seg_d = ~hex_decode(w_cur_val);
            end
            dp_d = ~(w_cur_dp & w_cur_en);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_board_io_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_io_frontend
//  Purpose  : Scoreboard bench: stimulus queues cycle-tagged expectations,
//             a negedge monitor compares them against two DUT configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_io_frontend;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;

    // Configuration A: 16 switches, 5 buttons, 4 digits
    logic [15:0] sw_pad;
    logic [4:0]  btn_pad;
    logic [15:0] sw_sync;
    logic [4:0]  btn_level, btn_press;
    logic [15:0] digit_val;
    logic [3:0]  digit_dp, digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    // Configuration B: 3 digits, exercises non-power-of-two wrap and blanking
    logic [1:0]  b_sw_pad, b_sw_sync;
    logic [0:0]  b_btn_pad, b_btn_level, b_btn_press;
    logic [11:0] b_digit_val;
    logic [2:0]  b_digit_dp, b_digit_en;
    logic [6:0]  b_seg;
    logic        b_dp;
    logic [2:0]  b_an;

    board_io_frontend #(
        .NUM_SW(16), .NUM_BTN(5), .NUM_DIGITS(4),
        .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(4)
    ) u_dut (
        .CLK(clk), .RST(rst),
        .sw_pad(sw_pad), .btn_pad(btn_pad),
        .sw_sync(sw_sync), .btn_level(btn_level), .btn_press(btn_press),
        .digit_val(digit_val), .digit_dp(digit_dp), .digit_en(digit_en),
        .seg(seg), .dp(dp), .an(an)
    );

    board_io_frontend #(
        .NUM_SW(2), .NUM_BTN(1), .NUM_DIGITS(3),
        .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(4)
    ) u_dut_b (
        .CLK(clk), .RST(rst),
        .sw_pad(b_sw_pad), .btn_pad(b_btn_pad),
        .sw_sync(b_sw_sync), .btn_level(b_btn_level), .btn_press(b_btn_press),
        .digit_val(b_digit_val), .digit_dp(b_digit_dp), .digit_en(b_digit_en),
        .seg(b_seg), .dp(b_dp), .an(b_an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    localparam int K_SW = 0, K_LVL = 1, K_PRS = 2, K_SEG = 3, K_DP = 4,
                   K_AN = 5, K_SEGB = 6, K_DPB = 7, K_ANB = 8;
    string kname [9] = '{"sw_sync", "btn_level", "btn_press", "seg", "dp",
                         "an", "b_seg", "b_dp", "b_an"};

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] v;
    } exp_t;

    exp_t sbq[$];
    int   nchecks = 0;
    int   nfail   = 0;

    function automatic void push(input int c, input int k, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.v    = v;
        sbq.push_back(e);
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_SW:    return 32'(sw_sync);
            K_LVL:   return 32'(btn_level);
            K_PRS:   return 32'(btn_press);
            K_SEG:   return 32'(seg);
            K_DP:    return 32'(dp);
            K_AN:    return 32'(an);
            K_SEGB:  return 32'(b_seg);
            K_DPB:   return 32'(b_dp);
            default: return 32'(b_an);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                logic [31:0] a;
                a = actual(sbq[i].kind);
                nchecks++;
                if (a !== sbq[i].v) begin
                    nfail++;
                    $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                             kname[sbq[i].kind], cyc, a, sbq[i].v);
                end
                sbq.delete(i);
            end else if (sbq[i].cyc < cyc) begin
                nchecks++;
                nfail++;
                $display("FAIL %s cycle %0d: expectation missed by monitor",
                         kname[sbq[i].kind], sbq[i].cyc);
                sbq.delete(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Expectation helpers
    // ------------------------------------------------------------------
    logic [6:0] seg_a [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] an_a  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic       dp_a  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] seg_b [3] = '{7'h19, 7'h7F, 7'h24};
    logic [2:0] an_b  [3] = '{3'h6, 3'h7, 3'h3};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_btn(input int from, input int to,
                            input logic [4:0] lvl, input logic [4:0] prs);
        for (int c = from; c <= to; c++) begin
            push(c, K_LVL, 32'(lvl));
            push(c, K_PRS, 32'(prs));
        end
    endtask

    // Scan starts with a dead-time cycle at edge r+1, then 3 lit cycles per digit.
    task automatic push_scan(input int r, input int n_a, input int n_b);
        for (int c = 1; c <= n_a; c++) begin
            int p, s;
            p = (c - 1) % 4;
            s = ((c - 1) / 4) % 4;
            push(r + c, K_SEG, (p == 0) ? 32'h7F : 32'(seg_a[s]));
            push(r + c, K_DP,  (p == 0) ? 32'h1  : 32'(dp_a[s]));
            push(r + c, K_AN,  (p == 0) ? 32'hF  : 32'(an_a[s]));
        end
        for (int c = 1; c <= n_b; c++) begin
            int p, s;
            p = (c - 1) % 4;
            s = ((c - 1) / 4) % 3;
            push(r + c, K_SEGB, (p == 0) ? 32'h7F : 32'(seg_b[s]));
            push(r + c, K_DPB,  32'h1);
            push(r + c, K_ANB,  (p == 0) ? 32'h7  : 32'(an_b[s]));
        end
    endtask

    task automatic push_reset_state(input int c);
        push(c, K_SW,   32'h0);
        push(c, K_LVL,  32'h0);
        push(c, K_PRS,  32'h0);
        push(c, K_SEG,  32'h7F);
        push(c, K_DP,   32'h1);
        push(c, K_AN,   32'hF);
        push(c, K_SEGB, 32'h7F);
        push(c, K_DPB,  32'h1);
        push(c, K_ANB,  32'h7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int         e;
        logic [7:0] pat;

        rst         = 1'b1;
        sw_pad      = '0;
        btn_pad     = '0;
        digit_val   = 16'h1234;
        digit_en    = 4'hF;
        digit_dp    = 4'h2;
        b_sw_pad    = '0;
        b_btn_pad   = '0;
        b_digit_val = 12'h234;
        b_digit_en  = 3'b101;
        b_digit_dp  = 3'b000;

        push_reset_state(1);
        step(2);
        rst = 1'b0;
        push_scan(cyc, 40, 24);

        // Switch synchroniser latency
        step(1);
        e = cyc;
        sw_pad = 16'hA5C3;
        push(e + 1, K_SW, 32'h0);
        push(e + 2, K_SW, 32'hA5C3);
        step(3);
        e = cyc;
        sw_pad = 16'h5A3C;
        push(e + 1, K_SW, 32'hA5C3);
        push(e + 2, K_SW, 32'h5A3C);
        step(3);

        // Clean press and release on button 2
        e = cyc;
        btn_pad = 5'b00100;
        push_btn(e + 1, e + 5, 5'b00000, 5'b00000);
        push_btn(e + 6, e + 6, 5'b00100, 5'b00100);
        push_btn(e + 7, e + 7, 5'b00100, 5'b00000);
        step(8);
        e = cyc;
        btn_pad = 5'b00000;
        push_btn(e + 1, e + 5, 5'b00100, 5'b00000);
        push_btn(e + 6, e + 7, 5'b00000, 5'b00000);
        step(8);

        // Bounce on button 0: two 3-sample bursts are rejected, then held high
        e = cyc;
        pat = 8'b0111_0111;
        push_btn(e + 1,  e + 13, 5'b00000, 5'b00000);
        push_btn(e + 14, e + 14, 5'b00001, 5'b00001);
        push_btn(e + 15, e + 15, 5'b00001, 5'b00000);
        for (int i = 0; i < 8; i++) begin
            btn_pad[0] = pat[i];
            step(1);
        end
        btn_pad[0] = 1'b1;
        step(8);
        e = cyc;
        btn_pad = 5'b00000;
        push_btn(e + 1, e + 5, 5'b00001, 5'b00000);
        push_btn(e + 6, e + 7, 5'b00000, 5'b00000);
        step(8);

        // Simultaneous presses on buttons 4 and 1
        e = cyc;
        btn_pad = 5'b10010;
        push_btn(e + 1, e + 5, 5'b00000, 5'b00000);
        push_btn(e + 6, e + 6, 5'b10010, 5'b10010);
        push_btn(e + 7, e + 7, 5'b10010, 5'b00000);
        step(8);
        btn_pad = 5'b00000;
        step(8);

        // Asynchronous reset mid-debounce and mid-scan
        btn_pad = 5'b01000;
        step(2);
        e = cyc;
        rst = 1'b1;
        push_reset_state(e);
        push_reset_state(e + 1);
        push_reset_state(e + 2);
        step(3);
        rst = 1'b0;
        push_btn(e + 3, e + 8, 5'b00000, 5'b00000);
        push_btn(e + 9, e + 9, 5'b01000, 5'b01000);
        push_btn(e + 10, e + 10, 5'b01000, 5'b00000);
        step(12);

        foreach (sbq[i]) begin
            nchecks++;
            nfail++;
            $display("FAIL %s cycle %0d: expectation never checked",
                     kname[sbq[i].kind], sbq[i].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchecks, nfail);
        $finish;
    end

endmodule
`default_nettype wire
